hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage MIPS core (IF, DEC, EXE, MEM, WB). It generates the stall, flush and operand-forwarding controls for the pipeline registers and tracks a multi-cycle mul/div unit with an internal busy counter. It also keeps saturating performance counters for stall cycles and flush events. Branch resolution is either in EXE or in DEC, selected by parameter.

## Interface
- `REG_W`, 5, register-address width
- `MD_LATENCY`, 32, mul/div busy cycles (≥2)
- `BRANCH_IN_DEC`, 0, 0 = branch resolved in EXE, 1 = resolved in DEC
- `CNT_W`, 32, perf-counter width

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `rs_DEC`, `rt_DEC`  in  REG_W  DEC source registers
- `uses_rs_DEC`, `uses_rt_DEC`  in  1  source actually read
- `is_branch_DEC`  in  1  DEC holds a branch/jump-register
- `md_op_DEC`, `hilo_read_DEC`  in  1  DEC holds mul/div, or mfhi/mflo
- `rs_EXE`, `rt_EXE`, `dst_EXE`  in  REG_W  EXE sources and destination
- `regwrite_EXE`, `memtoreg_EXE`, `md_start_EXE`  in  1  EXE controls
- `dst_MEM`  in  REG_W; `regwrite_MEM`, `memtoreg_MEM`  in  1
- `dst_WB`  in  REG_W; `regwrite_WB`  in  1
- `branch_taken`  in  1  taken redirect from the resolving stage
- `perf_clr`  in  1  synchronous clear of perf counters
- `stall_IF`, `stall_DEC`  out  1  hold PC and IF/DEC register
- `flush_DEC`, `flush_EXE`  out  1  load bubble into IF/DEC, DEC/EXE
- `fwd_a_EXE`, `fwd_b_EXE`  out  2  0 = regfile, 1 = WB, 2 = MEM
- `fwd_a_DEC`, `fwd_b_DEC`  out  1  branch comparator takes MEM result (BRANCH_IN_DEC only, else 0)
- `md_busy`  out  1  mul/div in progress
- `perf_stall_cnt`, `perf_flush_cnt`  out  CNT_W  saturating counters

## Operation
- Register match: `match(a,d,we)` = `we && d!=0 && a==d`. Register 0 never matches.
- EXE forwarding: fwd_a = 2 if match(rs_EXE, MEM). Else 1 if match(rs_EXE, WB). Else 0. The same rule applies to fwd_b with rt_EXE. MEM has priority over WB.
- Load-use (lu): `memtoreg_EXE` and a used DEC source matches dst_EXE.
- Branch operand hazard (bh, BRANCH_IN_DEC=1 only): `is_branch_DEC` and a used source either matches dst_EXE, or matches dst_MEM with `memtoreg_MEM`. fwd_x_DEC = match(src, MEM) && !memtoreg_MEM.
- Mul/div hazard (mh): `(md_busy || md_start_EXE) && (md_op_DEC || hilo_read_DEC)`.
- Stall request: `st = lu | bh | mh`.
- BRANCH_IN_DEC=0:
  - If branch_taken: flush_DEC=1, flush_EXE=1, stalls=0. The branch overrides st.
  - Else, if st: stall_IF=1, stall_DEC=1, flush_EXE=1.
- BRANCH_IN_DEC=1:
  - If st: stall_IF=1, stall_DEC=1, flush_EXE=1, and branch_taken is ignored.
  - Else, if branch_taken: flush_DEC=1 only.
- Mul/div FSM, states IDLE and BUSY:
  - IDLE→BUSY on `md_start_EXE`. Counter loads MD_LATENCY.
  - In BUSY, the counter decrements each cycle. BUSY→IDLE when the counter is 1.
  - `md_busy` = (state==BUSY).
  - `md_start_EXE` while BUSY is ignored; the counter is not reloaded.
  - Flushes and stalls do not abort BUSY, because the issuing instruction is older.
- Perf counters:
  - perf_stall_cnt increments on any cycle with stall_IF=1.
  - perf_flush_cnt increments on any cycle with flush_DEC=1.
  - Both saturate at all-ones. `perf_clr` zeroes both and has priority over increment.

## Timing
- Stall, flush and forward outputs are combinational from inputs and FSM state, with no added latency.
- md_busy is registered. After md_start_EXE is sampled at edge k, md_busy is high for exactly MD_LATENCY cycles after edge k. It is low from edge k+MD_LATENCY, and HI/LO are readable from that cycle.
- A load-use stall lasts exactly 1 cycle: the bubble moves the load to MEM.
- A bh stall on an EXE ALU producer lasts 1 cycle. A bh stall on an EXE load lasts 2 cycles.
- Reset:
  - While rst_n=0: FSM=IDLE, counter=0, md_busy=0, perf counters=0.
  - All stall, flush and fwd outputs are forced to 0 regardless of inputs.
  - Reset mid-BUSY aborts immediately.
- Counter width is $clog2(MD_LATENCY+1).

## Structure
- `hazard_pkg`: `fwd_sel_t` enum (FWD_RF=0, FWD_WB=1, FWD_MEM=2), `md_state_t` (IDLE, BUSY), and the match function.
- Sub-module `md_busy_tracker`: FSM plus down-counter, parameter MD_LATENCY, outputs md_busy.
- The top level holds the combinational hazard and priority logic and the perf counters.

## Test plan
- rs_EXE=5, dst_MEM=5 regwrite_MEM, and dst_WB=5 regwrite_WB → fwd_a_EXE=2. Change dst_MEM to 0 → fwd_a_EXE=1.
- memtoreg_EXE, dst_EXE=8, rt_DEC=8, uses_rt_DEC → stall_IF=stall_DEC=flush_EXE=1 for one cycle, perf_stall_cnt +1. Repeat with dst_EXE=0 → no stall.
- MD_LATENCY=4, md_start_EXE at edge 0, hilo_read_DEC held → stall in the start cycle and for 4 busy cycles. md_busy falls at edge 4.
- BRANCH_IN_DEC=0, branch_taken with a simultaneous load-use → flush_DEC=flush_EXE=1, stall_IF=0.
- BRANCH_IN_DEC=1, is_branch_DEC, rs_DEC=3, dst_EXE=3 load → stall 2 cycles. Then fwd_a_DEC=0 with WB path, branch_taken → flush_DEC only.
- Assert rst_n=0 during BUSY and during a stall → md_busy=0 and all outputs 0 asynchronously. perf_clr with a stall in the same cycle → counter reads 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the hazard controller.
// Forward-select encoding, mul/div FSM states and register match.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  // Register 0 is hard-wired, so it never carries a hazard.
  function automatic logic reg_match(
    input logic [31:0] a,
    input logic [31:0] d,
    input logic        we
  );
    return we && (d != 32'd0) && (a == d);
  endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// md_busy_tracker: IDLE/BUSY FSM with a down-counter for mul/div.
// Ports: clk, rst_n, md_start_i (start pulse), md_busy_o (registered busy).
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start_i,
  output logic md_busy_o
);

  localparam int CW = $clog2(MD_LATENCY + 1);

  md_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A start seen while BUSY is dropped: the unit is already occupied.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (md_start_i) begin
          state_d = BUSY;
          cnt_d   = CW'(MD_LATENCY);
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign md_busy_o = (state_q == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control for the 5-stage pipeline.
// Ports: stage register/control inputs, stall/flush/fwd outputs, perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W         = 5,
  parameter int MD_LATENCY    = 32,
  parameter int BRANCH_IN_DEC = 0,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs_DEC,
  input  logic [REG_W-1:0] rt_DEC,
  input  logic             uses_rs_DEC,
  input  logic             uses_rt_DEC,
  input  logic             is_branch_DEC,
  input  logic             md_op_DEC,
  input  logic             hilo_read_DEC,
  input  logic [REG_W-1:0] rs_EXE,
  input  logic [REG_W-1:0] rt_EXE,
  input  logic [REG_W-1:0] dst_EXE,
  input  logic             regwrite_EXE,
  input  logic             memtoreg_EXE,
  input  logic             md_start_EXE,
  input  logic [REG_W-1:0] dst_MEM,
  input  logic             regwrite_MEM,
  input  logic             memtoreg_MEM,
  input  logic [REG_W-1:0] dst_WB,
  input  logic             regwrite_WB,
  input  logic             branch_taken,
  input  logic             perf_clr,
  output logic             stall_IF,
  output logic             stall_DEC,
  output logic             flush_DEC,
  output logic             flush_EXE,
  output logic [1:0]       fwd_a_EXE,
  output logic [1:0]       fwd_b_EXE,
  output logic             fwd_a_DEC,
  output logic             fwd_b_DEC,
  output logic             md_busy,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  logic lu, bh, mh, st;
  logic st_if, st_dec, fl_dec, fl_exe;
  logic fad, fbd;
  fwd_sel_t fa, fb;
  logic [CNT_W-1:0] pstall_q, pstall_d;
  logic [CNT_W-1:0] pflush_q, pflush_d;

  function automatic logic hit(
    input logic [REG_W-1:0] a,
    input logic [REG_W-1:0] d,
    input logic             we
  );
    return reg_match(32'(a), 32'(d), we);
  endfunction

  md_busy_tracker #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md (
    .clk       (clk),
    .rst_n     (rst_n),
    .md_start_i(md_start_EXE),
    .md_busy_o (md_busy)
  );

  always_comb begin
    lu = memtoreg_EXE &&
      ((uses_rs_DEC && hit(rs_DEC, dst_EXE, regwrite_EXE)) ||
       (uses_rt_DEC && hit(rt_DEC, dst_EXE, regwrite_EXE)));
    bh  = 1'b0;
    fad = 1'b0;
    fbd = 1'b0;
    // A load in MEM cannot feed the DEC comparator yet; an ALU result can.
    if (BRANCH_IN_DEC != 0) begin
      bh = is_branch_DEC && (
        (uses_rs_DEC &&
          (hit(rs_DEC, dst_EXE, regwrite_EXE) ||
           (memtoreg_MEM && hit(rs_DEC, dst_MEM, regwrite_MEM)))) ||
        (uses_rt_DEC &&
          (hit(rt_DEC, dst_EXE, regwrite_EXE) ||
           (memtoreg_MEM && hit(rt_DEC, dst_MEM, regwrite_MEM)))));
      fad = hit(rs_DEC, dst_MEM, regwrite_MEM) && !memtoreg_MEM;
      fbd = hit(rt_DEC, dst_MEM, regwrite_MEM) && !memtoreg_MEM;
    end
    mh = (md_busy || md_start_EXE) && (md_op_DEC || hilo_read_DEC);
    st = lu | bh | mh;
  end

  // EXE branches override stalls; DEC branches wait for their operands.
  always_comb begin
    st_if  = 1'b0;
    st_dec = 1'b0;
    fl_dec = 1'b0;
    fl_exe = 1'b0;
    if (BRANCH_IN_DEC == 0) begin
      if (branch_taken) begin
        fl_dec = 1'b1;
        fl_exe = 1'b1;
      end else if (st) begin
        st_if  = 1'b1;
        st_dec = 1'b1;
        fl_exe = 1'b1;
      end
    end else begin
      if (st) begin
        st_if  = 1'b1;
        st_dec = 1'b1;
        fl_exe = 1'b1;
      end else if (branch_taken) begin
        fl_dec = 1'b1;
      end
    end
  end

  // MEM holds the younger result, so it wins over WB.
  always_comb begin
    fa = FWD_RF;
    fb = FWD_RF;
    if (hit(rs_EXE, dst_MEM, regwrite_MEM)) fa = FWD_MEM;
    else if (hit(rs_EXE, dst_WB, regwrite_WB)) fa = FWD_WB;
    if (hit(rt_EXE, dst_MEM, regwrite_MEM)) fb = FWD_MEM;
    else if (hit(rt_EXE, dst_WB, regwrite_WB)) fb = FWD_WB;
  end

  assign stall_IF  = rst_n & st_if;
  assign stall_DEC = rst_n & st_dec;
  assign flush_DEC = rst_n & fl_dec;
  assign flush_EXE = rst_n & fl_exe;
  assign fwd_a_EXE = rst_n ? fa : FWD_RF;
  assign fwd_b_EXE = rst_n ? fb : FWD_RF;
  assign fwd_a_DEC = rst_n & fad;
  assign fwd_b_DEC = rst_n & fbd;

  always_comb begin
    pstall_d = pstall_q;
    pflush_d = pflush_q;
    if (perf_clr) begin
      pstall_d = '0;
      pflush_d = '0;
    end else begin
      if (stall_IF && (pstall_q != '1)) pstall_d = pstall_q + CNT_W'(1);
      if (flush_DEC && (pflush_q != '1)) pflush_d = pflush_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstall_q <= '0;
      pflush_q <= '0;
    end else begin
      pstall_q <= pstall_d;
      pflush_q <= pflush_d;
    end
  end

  assign perf_stall_cnt = pstall_q;
  assign perf_flush_cnt = pflush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl, both branch modes.
// Directed test-plan sequences followed by randomized cycles.
module tb_hazard_ctrl;

  localparam int L    = 4;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  typedef struct packed {
    logic [4:0] rs_DEC;
    logic [4:0] rt_DEC;
    logic       uses_rs;
    logic       uses_rt;
    logic       is_br;
    logic       md_op;
    logic       hilo;
    logic [4:0] rs_EXE;
    logic [4:0] rt_EXE;
    logic [4:0] dst_EXE;
    logic       rw_EXE;
    logic       m2r_EXE;
    logic       start;
    logic [4:0] dst_MEM;
    logic       rw_MEM;
    logic       m2r_MEM;
    logic [4:0] dst_WB;
    logic       rw_WB;
    logic       bt;
    logic       clr;
  } in_t;

  typedef struct packed {
    logic          si;
    logic          sd;
    logic          fd;
    logic          fe;
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic          fad;
    logic          fbd;
    logic          busy;
    logic [CW-1:0] ps;
    logic [CW-1:0] pf;
  } out_t;

  typedef struct packed {
    out_t e0;
    out_t e1;
  } pair_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  in_t  in = '0;

  logic          si   [2];
  logic          sd   [2];
  logic          fd   [2];
  logic          fe   [2];
  logic [1:0]    fa   [2];
  logic [1:0]    fb   [2];
  logic          fad  [2];
  logic          fbd  [2];
  logic          busy [2];
  logic [CW-1:0] ps   [2];
  logic [CW-1:0] pf   [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int busy_end = 0;
  int ps_m [2] = '{0, 0};
  int pf_m [2] = '{0, 0};
  out_t cur [2];
  pair_t sb [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    hazard_ctrl #(
      .REG_W(5),
      .MD_LATENCY(L),
      .BRANCH_IN_DEC(g),
      .CNT_W(CW)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rs_DEC        (in.rs_DEC),
      .rt_DEC        (in.rt_DEC),
      .uses_rs_DEC   (in.uses_rs),
      .uses_rt_DEC   (in.uses_rt),
      .is_branch_DEC (in.is_br),
      .md_op_DEC     (in.md_op),
      .hilo_read_DEC (in.hilo),
      .rs_EXE        (in.rs_EXE),
      .rt_EXE        (in.rt_EXE),
      .dst_EXE       (in.dst_EXE),
      .regwrite_EXE  (in.rw_EXE),
      .memtoreg_EXE  (in.m2r_EXE),
      .md_start_EXE  (in.start),
      .dst_MEM       (in.dst_MEM),
      .regwrite_MEM  (in.rw_MEM),
      .memtoreg_MEM  (in.m2r_MEM),
      .dst_WB        (in.dst_WB),
      .regwrite_WB   (in.rw_WB),
      .branch_taken  (in.bt),
      .perf_clr      (in.clr),
      .stall_IF      (si[g]),
      .stall_DEC     (sd[g]),
      .flush_DEC     (fd[g]),
      .flush_EXE     (fe[g]),
      .fwd_a_EXE     (fa[g]),
      .fwd_b_EXE     (fb[g]),
      .fwd_a_DEC     (fad[g]),
      .fwd_b_DEC     (fbd[g]),
      .md_busy       (busy[g]),
      .perf_stall_cnt(ps[g]),
      .perf_flush_cnt(pf[g])
    );
  end

  function automatic bit mt(logic [4:0] a, logic [4:0] d, logic we);
    return we && d != 0 && a == d;
  endfunction

  function automatic bit bsrc(bit u, logic [4:0] s, in_t x);
    return u && (mt(s, x.dst_EXE, x.rw_EXE) ||
      (x.m2r_MEM && mt(s, x.dst_MEM, x.rw_MEM)));
  endfunction

  function automatic logic [1:0] fsel(logic [4:0] s, in_t x);
    if (mt(s, x.dst_MEM, x.rw_MEM)) return 2'd2;
    if (mt(s, x.dst_WB, x.rw_WB)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic out_t model(in_t x, int bid, bit bz,
                                 int cs, int cf, bit rn);
    out_t o;
    bit lu, bh, mh, st;
    o = '0;
    if (!rn) return o;
    lu = x.m2r_EXE &&
      ((x.uses_rs && mt(x.rs_DEC, x.dst_EXE, x.rw_EXE)) ||
       (x.uses_rt && mt(x.rt_DEC, x.dst_EXE, x.rw_EXE)));
    bh = bid == 1 && x.is_br &&
      (bsrc(x.uses_rs, x.rs_DEC, x) || bsrc(x.uses_rt, x.rt_DEC, x));
    mh = (bz || x.start) && (x.md_op || x.hilo);
    st = lu || bh || mh;
    if (bid == 0) begin
      if (x.bt) begin
        o.fd = 1; o.fe = 1;
      end else if (st) begin
        o.si = 1; o.sd = 1; o.fe = 1;
      end
    end else begin
      if (st) begin
        o.si = 1; o.sd = 1; o.fe = 1;
      end else if (x.bt) begin
        o.fd = 1;
      end
    end
    o.fa = fsel(x.rs_EXE, x);
    o.fb = fsel(x.rt_EXE, x);
    o.fad = bid == 1 && mt(x.rs_DEC, x.dst_MEM, x.rw_MEM) && !x.m2r_MEM;
    o.fbd = bid == 1 && mt(x.rt_DEC, x.dst_MEM, x.rw_MEM) && !x.m2r_MEM;
    o.busy = bz;
    o.ps = CW'(cs);
    o.pf = CW'(cf);
    return o;
  endfunction

  task automatic step(in_t nx, bit r);
    @(posedge clk);
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (in.clr) begin
          ps_m[i] = 0;
          pf_m[i] = 0;
        end else begin
          if (cur[i].si && ps_m[i] < MAXC) ps_m[i]++;
          if (cur[i].fd && pf_m[i] < MAXC) pf_m[i]++;
        end
      end
      if (in.start && !(cyc < busy_end)) busy_end = cyc + 1 + L;
    end
    cyc++;
    #1;
    rst_n = r;
    in = nx;
    if (!r) begin
      ps_m = '{0, 0};
      pf_m = '{0, 0};
      busy_end = 0;
    end
    for (int i = 0; i < 2; i++)
      cur[i] = model(in, i, cyc < busy_end, ps_m[i], pf_m[i], r);
    sb.push_back({cur[0], cur[1]});
  endtask

  task automatic cmp(int i, string nm, logic [31:0] a, logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc%0d: got %0d expected %0d",
               nm, i, cyc, a, e);
    end
  endtask

  task automatic check(int i, out_t e);
    cmp(i, "stall_IF", 32'(si[i]), 32'(e.si));
    cmp(i, "stall_DEC", 32'(sd[i]), 32'(e.sd));
    cmp(i, "flush_DEC", 32'(fd[i]), 32'(e.fd));
    cmp(i, "flush_EXE", 32'(fe[i]), 32'(e.fe));
    cmp(i, "fwd_a_EXE", 32'(fa[i]), 32'(e.fa));
    cmp(i, "fwd_b_EXE", 32'(fb[i]), 32'(e.fb));
    cmp(i, "fwd_a_DEC", 32'(fad[i]), 32'(e.fad));
    cmp(i, "fwd_b_DEC", 32'(fbd[i]), 32'(e.fbd));
    cmp(i, "md_busy", 32'(busy[i]), 32'(e.busy));
    cmp(i, "perf_stall", 32'(ps[i]), 32'(e.ps));
    cmp(i, "perf_flush", 32'(pf[i]), 32'(e.pf));
  endtask

  pair_t p;
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        p = sb.pop_front();
        check(0, p.e0);
        check(1, p.e1);
      end
    end
  end

  function automatic logic [4:0] r5();
    return 5'($urandom_range(0, 3));
  endfunction

  function automatic bit b(int n);
    return $urandom_range(0, n - 1) == 0;
  endfunction

  function automatic in_t rnd();
    in_t x;
    x.rs_DEC  = r5();
    x.rt_DEC  = r5();
    x.uses_rs = b(2);
    x.uses_rt = b(2);
    x.is_br   = b(3);
    x.md_op   = b(5);
    x.hilo    = b(5);
    x.rs_EXE  = r5();
    x.rt_EXE  = r5();
    x.dst_EXE = r5();
    x.m2r_EXE = b(3);
    x.rw_EXE  = b(2) | x.m2r_EXE;
    x.start   = b(8);
    x.dst_MEM = r5();
    x.m2r_MEM = b(3);
    x.rw_MEM  = b(2) | x.m2r_MEM;
    x.dst_WB  = r5();
    x.rw_WB   = b(2);
    x.bt      = b(4);
    x.clr     = b(16);
    return x;
  endfunction

  in_t x, lu_x;
  initial begin
    repeat (3) step(rnd(), 0);
    step('0, 1);
    // forwarding priority
    x = '0;
    x.rs_EXE = 5; x.dst_MEM = 5; x.rw_MEM = 1;
    x.dst_WB = 5; x.rw_WB = 1;
    step(x, 1);
    x.dst_MEM = 0;
    step(x, 1);
    // load-use then bubble
    lu_x = '0;
    lu_x.m2r_EXE = 1; lu_x.rw_EXE = 1; lu_x.dst_EXE = 8;
    lu_x.rt_DEC = 8; lu_x.uses_rt = 1;
    step(lu_x, 1);
    step('0, 1);
    x = lu_x; x.dst_EXE = 0;
    step(x, 1);
    // mul/div with hilo read held
    x = '0; x.start = 1; x.hilo = 1;
    step(x, 1);
    x.start = 0;
    repeat (5) step(x, 1);
    // taken branch with load-use in the same cycle
    x = lu_x; x.bt = 1;
    step(x, 1);
    // DEC branch on an EXE load: two stall cycles then resolve
    x = '0; x.is_br = 1; x.uses_rs = 1; x.rs_DEC = 3;
    x.dst_EXE = 3; x.m2r_EXE = 1; x.rw_EXE = 1;
    step(x, 1);
    x.dst_EXE = 0; x.m2r_EXE = 0; x.rw_EXE = 0;
    x.dst_MEM = 3; x.m2r_MEM = 1; x.rw_MEM = 1;
    step(x, 1);
    x.dst_MEM = 0; x.m2r_MEM = 0; x.rw_MEM = 0;
    x.dst_WB = 3; x.rw_WB = 1; x.bt = 1;
    step(x, 1);
    // saturation of both counters
    x = lu_x;
    repeat (18) step(x, 1);
    x = '0; x.bt = 1;
    repeat (18) step(x, 1);
    // clear wins over a same-cycle stall
    x = lu_x; x.clr = 1;
    step(x, 1);
    step('0, 1);
    // reset while busy and stalling
    x = '0; x.start = 1;
    step(x, 1);
    x = lu_x; x.md_op = 1;
    step(x, 1);
    step(x, 0);
    step(x, 0);
    step('0, 1);
    step('0, 1);
    // random traffic with occasional resets
    repeat (600) step(rnd(), !b(60));
    step('0, 1);
    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
